// File: rtl/sv39_walker_pkg.sv
// Shared types for the Sv39 page-table walker.
// Holds bus bundles, PTE/SATP layouts and the walker state encoding.
package sv39_walker_pkg;

    localparam logic [3:0] SATP_MODE_SV39 = 4'h8;
    localparam int         PTE_SIZE       = 8;

    typedef enum logic [1:0] {
        MSIZE1,
        MSIZE2,
        MSIZE4,
        MSIZE8
    } msize_e;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_e      size;
        logic [7:0]  strobe;
        logic [63:0] wdata;
    } dbus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic [9:0]  rsvd;
        logic [43:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    typedef struct packed {
        logic [3:0]  mode;
        logic [15:0] asid;
        logic [43:0] ppn;
    } satp_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYPASS,
        S_WALK,
        S_DONE
    } state_e;

endpackage

// File: rtl/sv39_walker_pte_check.sv
// Combinational PTE decode: leaf detection, fault and
// superpage alignment for the current walk level.
module pte_check
    import sv39_walker_pkg::*;
(
    input  pte_t       pte,
    input  logic [1:0] lvl,
    output logic       leaf,
    output logic       fault
);

    logic misalign;
    logic unused_pte;

    assign unused_pte = ^{pte.rsvd, pte.rsw, pte.d, pte.a, pte.g, pte.u};

    always_comb begin
        leaf     = pte.r | pte.x;
        misalign = ((lvl == 2'd2) && (pte.ppn[17:0] != 18'd0))
                || ((lvl == 2'd1) && (pte.ppn[8:0] != 9'd0));
        fault    = !pte.v
                || (!pte.r && pte.w)
                || (leaf && misalign)
                || (!leaf && (lvl == 2'd0));
    end

endmodule

// File: rtl/sv39_walker.sv
// Sv39 hardware page-table walker shared by instruction and data sides,
// with bypass for machine mode / bare translation and flush handling.
module sv39_walker
    import sv39_walker_pkg::*;
#(
    parameter int RR_ARB  = 1,
    parameter int PA_BITS = 56
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] satp,
    input  logic [1:0]  mode,
    input  logic        flush,
    input  logic        i_valid,
    input  logic [63:0] i_vaddr,
    output logic        i_ok,
    output logic        i_fault,
    output logic [63:0] i_paddr,
    input  logic        d_valid,
    input  logic [63:0] d_vaddr,
    output logic        d_ok,
    output logic        d_fault,
    output logic [63:0] d_paddr,
    output dbus_req_t   ptw_req,
    input  dbus_resp_t  ptw_resp,
    output logic        busy
);

    localparam logic [63:0] PA_MASK = (PA_BITS >= 64) ? {64{1'b1}}
                                    : ((64'd1 << PA_BITS) - 64'd1);

    state_e      state_q, state_d;
    logic [1:0]  lvl_q, lvl_d;
    logic        last_q, last_d;
    logic        side_q, side_d;
    logic        flush_q, flush_d;
    logic [63:0] va_q, va_d;
    logic [63:0] addr_q, addr_d;
    logic        i_ok_q, i_ok_d;
    logic        d_ok_q, d_ok_d;
    logic        fault_q, fault_d;
    logic [63:0] paddr_q, paddr_d;

    satp_t       satp_s;
    pte_t        pte;
    logic        leaf;
    logic        pte_fault;
    logic        pick;
    logic [63:0] va_sel;
    logic [8:0]  vpn_next;
    logic [63:0] leaf_pa;
    logic        unused_satp;

    assign satp_s      = satp_t'(satp);
    assign pte         = pte_t'(ptw_resp.data);
    assign unused_satp = ^satp_s.asid;

    pte_check u_pte_check (
        .pte  (pte),
        .lvl  (lvl_q),
        .leaf (leaf),
        .fault(pte_fault)
    );

    always_comb begin
        pick     = d_valid && (!i_valid || ((RR_ARB != 0) && !last_q));
        va_sel   = pick ? d_vaddr : i_vaddr;
        vpn_next = (lvl_q == 2'd2) ? va_q[29:21] : va_q[20:12];
        unique case (lvl_q)
            2'd0:    leaf_pa = {8'd0, pte.ppn, va_q[11:0]};
            2'd1:    leaf_pa = {8'd0, pte.ppn[43:9], va_q[20:0]};
            default: leaf_pa = {8'd0, pte.ppn[43:18], va_q[29:0]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        last_d  = last_q;
        side_d  = side_q;
        flush_d = flush_q;
        va_d    = va_q;
        addr_d  = addr_q;
        i_ok_d  = 1'b0;
        d_ok_d  = 1'b0;
        fault_d = 1'b0;
        paddr_d = 64'd0;
        unique case (state_q)
            S_IDLE: begin
                flush_d = 1'b0;
                if (i_valid || d_valid) begin
                    side_d  = pick;
                    last_d  = pick;
                    va_d    = va_sel;
                    lvl_d   = 2'd2;
                    addr_d  = {8'd0, satp_s.ppn, 12'd0}
                            + {52'd0, va_sel[38:30], 3'd0};
                    state_d = ((mode == 2'd3) || (satp_s.mode != SATP_MODE_SV39))
                            ? S_BYPASS : S_WALK;
                end
            end
            S_BYPASS: begin
                if (flush || flush_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    i_ok_d  = !side_q;
                    d_ok_d  = side_q;
                    paddr_d = va_q;
                end
            end
            S_WALK: begin
                if (flush) flush_d = 1'b1;
                // The read in flight must retire before we abandon the walk.
                if (ptw_resp.data_ok) begin
                    if (flush || flush_q) begin
                        state_d = S_IDLE;
                    end else if (pte_fault || leaf) begin
                        state_d = S_DONE;
                        i_ok_d  = !side_q;
                        d_ok_d  = side_q;
                        fault_d = pte_fault;
                        paddr_d = pte_fault ? 64'd0 : (leaf_pa & PA_MASK);
                    end else begin
                        addr_d = {8'd0, pte.ppn, 12'd0}
                               + {52'd0, vpn_next, 3'd0};
                        lvl_d  = lvl_q - 2'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            lvl_q   <= 2'd2;
            last_q  <= 1'b1;
            side_q  <= 1'b0;
            flush_q <= 1'b0;
            va_q    <= 64'd0;
            addr_q  <= 64'd0;
            i_ok_q  <= 1'b0;
            d_ok_q  <= 1'b0;
            fault_q <= 1'b0;
            paddr_q <= 64'd0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            last_q  <= last_d;
            side_q  <= side_d;
            flush_q <= flush_d;
            va_q    <= va_d;
            addr_q  <= addr_d;
            i_ok_q  <= i_ok_d;
            d_ok_q  <= d_ok_d;
            fault_q <= fault_d;
            paddr_q <= paddr_d;
        end
    end

    always_comb begin
        i_ok           = i_ok_q && !flush;
        d_ok           = d_ok_q && !flush;
        i_fault        = i_ok && fault_q;
        d_fault        = d_ok && fault_q;
        i_paddr        = i_ok ? paddr_q : 64'd0;
        d_paddr        = d_ok ? paddr_q : 64'd0;
        busy           = (state_q != S_IDLE);
        ptw_req.valid  = (state_q == S_WALK);
        ptw_req.addr   = addr_q;
        ptw_req.size   = MSIZE8;
        ptw_req.strobe = 8'd0;
        ptw_req.wdata  = 64'd0;
    end

endmodule

// File: doc/sv39_walker.md
SV39_WALKER -- requirements
Module: sv39_walker

Interface
REQ-001 The module SHALL have parameter RR_ARB, default 1, meaning round-robin grant between requesters (0 = instruction side always wins).
REQ-002 The module SHALL have parameter PA_BITS, default 56, meaning physical address width before zero-extension to 64.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 satp  input  64  translation root; [63:60] mode, [43:0] ppn.
REQ-007 mode  input  2  current privilege (3 = machine).
REQ-008 flush  input  1  discard any in-flight result.
REQ-009 i_valid, i_vaddr  input  1/64  instruction-side translate request.
REQ-010 i_ok, i_fault, i_paddr  output  1/1/64  instruction-side one-cycle completion.
REQ-011 d_valid, d_vaddr  input  1/64  data-side translate request.
REQ-012 d_ok, d_fault, d_paddr  output  1/1/64  data-side one-cycle completion.
REQ-013 ptw_req  output  dbus_req_t  page-table read port.
REQ-014 ptw_resp  input  dbus_resp_t  page-table read response.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 States SHALL be IDLE, BYPASS, WALK, DONE; level counter lvl is 2..0.
REQ-017 Each requester SHALL hold valid and vaddr stable until its ok pulse; ok, fault and paddr SHALL be valid for exactly one cycle.
REQ-018 In IDLE with exactly one valid, that side SHALL be granted; with both valid, RR_ARB=1 SHALL grant the side not granted last (instruction side first after reset), and RR_ARB=0 SHALL grant the instruction side.
REQ-019 On grant, vaddr and side SHALL be latched; a requester's later input changes SHALL NOT affect the walk.
REQ-020 If mode==3 or satp[63:60]!=4'h8, the FSM SHALL go to BYPASS, and the next cycle SHALL produce ok with paddr=vaddr and fault=0 (latency 1).
REQ-021 Otherwise the FSM SHALL go to WALK with lvl=2 and PTE address {satp.ppn,12'b0}+8*vaddr[38:30].
REQ-022 In WALK, ptw_req SHALL be valid=1, size=MSIZE8, strobe=0, and held constant until ptw_resp.data_ok.
REQ-023 On data_ok, a PTE with V=0, or with R=0 and W=1, SHALL be a fault.
REQ-024 On data_ok, a PTE with R|X=1 SHALL be a leaf; a misaligned superpage (lvl=2 with ppn[17:0]!=0, or lvl=1 with ppn[8:0]!=0) SHALL be a fault.
REQ-025 Leaf paddr SHALL be: lvl 0 {pte[53:10],va[11:0]}; lvl 1 {pte[53:19],va[20:0]}; lvl 2 {pte[53:28],va[29:0]}; zero-extended to 64 bits.
REQ-026 A non-leaf PTE at lvl>0 SHALL set the next address to {pte[53:10],12'b0}+8*VPN[lvl-1] and decrement lvl; a non-leaf PTE at lvl 0 SHALL be a fault.
REQ-027 DONE SHALL pulse the granted side's ok with paddr/fault for one cycle, then return to IDLE; a new grant SHALL NOT occur in that same cycle.
REQ-028 Fault completions SHALL drive paddr=0.
REQ-029 When flush is asserted during BYPASS or WALK, the outstanding bus read SHALL complete and the FSM SHALL return to IDLE with no ok pulse; flush in IDLE or DONE SHALL suppress that cycle's ok.
REQ-030 Walk latency without stalls SHALL be 1 cycle per level plus 1 DONE cycle.
REQ-031 In IDLE, ptw_req.valid SHALL be 0.

Reset
REQ-032 Asserting reset SHALL immediately force IDLE, lvl=2, last-grant=data side, ptw_req.valid=0, all ok/fault=0, paddr=0 and busy=0, including mid-walk.
REQ-033 A bus response that arrives after reset SHALL be ignored.

Structure
REQ-034 The shared package SHALL hold pte_t (V,R,W,X,U,G,A,D,RSW,ppn), satp_t, SATP_MODE_SV39=4'h8, PTE_SIZE=8 and the state enum.
REQ-035 One sub-module, pte_check, SHALL hold the combinational leaf, fault and superpage-alignment decode.

Verification
REQ-036 Scenario 1: mode=3, i_vaddr=0x8000_1234 -> i_ok one cycle later, i_paddr=0x8000_1234, no ptw_req.valid.
REQ-037 Scenario 2: satp mode=8, ppn=0x80000, three-level table mapping va 0x4000_2ABC to ppn 0x80123 -> reads at 0x8000_0008 then two further levels, d_paddr=0x8012_3ABC, 4 cycles with zero-wait memory.
REQ-038 Scenario 3: same-cycle i_valid and d_valid, repeated twice, RR_ARB=1 -> grant order I, D, I, D.
REQ-039 Scenario 4: level-1 PTE=0x0 (V=0) -> d_fault=1, d_paddr=0, exactly two bus reads.
REQ-040 Scenario 5: lvl-2 leaf with ppn=0x80001 (misaligned gigapage) -> fault; aligned ppn 0x80000, va 0x4012_3456 -> paddr 0x8012_3456.
REQ-041 Scenario 6: flush while data_ok is withheld 3 cycles -> no ok pulse and IDLE after data_ok; reset asserted mid-walk -> busy=0 and ptw_req.valid=0 immediately.
